// File: rtl/mem_unified_ram.sv
// Unified instruction/data memory for the RV32I pipeline.
// The IF-side port fetches with one cycle of latency. The MEM-side port has a
// configurable load latency, byte-lane stores, and alignment and range checks.
// Both ports decode addresses against BASE_ADDR. The array maps onto a dual-port block RAM.

package mem_unified_ram_pkg;
  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] size;      // 00 byte, 01 half, 10 word
    logic       sign;      // 1 = zero-extend loads
  } mem_ctrl_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
endpackage

module mem_unified_ram
  import mem_unified_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 8192,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned DATA_LATENCY  = 1,
  parameter string       INIT_FILENAME = "test_rv32i.bin"
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        en_IF,
  input  logic [31:0] i_instrAddr,
  output logic [31:0] o_instr,
  output logic        o_instrFault,
  input  logic        en_MEM,
  input  logic [31:0] i_memAddr,
  input  logic [31:0] i_writeData,
  input  mem_ctrl_t   i_ctrlMEM,
  output logic [31:0] o_readData,
  output logic        o_readValid,
  output logic        o_memBusy,
  output logic        o_misaligned,
  output logic        o_accessFault
);

  localparam int unsigned ADDR_BITS  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES  = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic        MULTI      = (DATA_LATENCY > 1);
  localparam int unsigned CNT_LAST_I = (DATA_LATENCY > 1) ? DATA_LATENCY - 2 : 0;
  localparam logic [1:0]  CNT_LAST   = CNT_LAST_I[1:0];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] instr_word;
  logic [31:0] ld_pipe [DATA_LATENCY];

  // Fetch-side decode.
  logic [31:0]          if_offset;
  logic                 if_ok;
  logic [ADDR_BITS-1:0] if_idx;
  assign if_offset = i_instrAddr - BASE_ADDR;
  assign if_ok     = (if_offset < MEM_BYTES) && (i_instrAddr[1:0] == 2'b00);
  assign if_idx    = if_offset[ADDR_BITS+1:2];

  // Data-side decode.
  logic [31:0]          mem_offset;
  logic                 mem_in_range;
  logic [ADDR_BITS-1:0] mem_idx;
  logic                 mem_misaligned;
  logic                 mem_req, is_load;
  logic                 accept_ld, accept_st, rej_mis, rej_af;
  assign mem_offset   = i_memAddr - BASE_ADDR;
  assign mem_in_range = mem_offset < MEM_BYTES;
  assign mem_idx      = mem_offset[ADDR_BITS+1:2];
  assign mem_req      = en_MEM && (i_ctrlMEM.memRead || i_ctrlMEM.memWrite) && !o_memBusy;
  assign is_load      = i_ctrlMEM.memRead;
  assign accept_ld    = mem_req && is_load && !mem_misaligned && mem_in_range;
  assign accept_st    = mem_req && !is_load && !mem_misaligned && mem_in_range;
  assign rej_mis      = mem_req && mem_misaligned;
  assign rej_af       = mem_req && !mem_misaligned && !mem_in_range;

  // Alignment check and store lane steering.
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mem_misaligned = 1'b1;
    st_be          = 4'b0000;
    st_wdata       = i_writeData;
    case (i_ctrlMEM.size)
      SIZE_B: begin
        mem_misaligned = 1'b0;
        st_be          = 4'b0001 << i_memAddr[1:0];
        st_wdata       = {4{i_writeData[7:0]}};
      end
      SIZE_H: begin
        mem_misaligned = i_memAddr[0];
        st_be          = i_memAddr[1] ? 4'b1100 : 4'b0011;
        st_wdata       = {2{i_writeData[15:0]}};
      end
      SIZE_W: begin
        mem_misaligned = (i_memAddr[1:0] != 2'b00);
        st_be          = 4'b1111;
      end
      default: mem_misaligned = 1'b1;
    endcase
  end

  // Array ports: read-first fetch, data read or byte-lane write, load data pipeline.
  always_ff @(posedge i_clk) begin
    // NOTE: the array and its read registers are not reset; a reset would block block-RAM mapping
    // and contents must survive reset anyway.
    if (en_IF && if_ok) instr_word <= mem[if_idx];
    if (accept_ld) ld_pipe[0] <= mem[mem_idx];
    if (accept_st) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[mem_idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
    for (int k = 1; k < DATA_LATENCY; k++) ld_pipe[k] <= ld_pipe[k-1];
  end

  // Sign or zero extension of the selected lane, applied at the output stage.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic zext);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      SIZE_B:  return zext ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  return zext ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: return word;
    endcase
  endfunction

  // Control state.
  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  ld_lane_q, ld_lane_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_zext_q, ld_zext_d;
  logic        rej_ld_q, rej_ld_d;
  logic        mis_q, mis_d;
  logic        af_q, af_d;
  logic [31:0] rd_hold_q, rd_hold_d;
  logic        instr_live_q, instr_live_d;
  logic        instr_fault_q, instr_fault_d;

  // Next-state logic for the load FSM, captured request fields, pulses and fetch status.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_lane_d     = ld_lane_q;
    ld_size_d     = ld_size_q;
    ld_zext_d     = ld_zext_q;
    instr_live_d  = instr_live_q;
    instr_fault_d = instr_fault_q;
    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = ST_RESP;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Acceptance is only possible in IDLE, or in RESP when the latency is one cycle.
    if (accept_ld) begin
      state_d   = MULTI ? ST_WAIT : ST_RESP;
      cnt_d     = 2'd0;
      ld_lane_d = i_memAddr[1:0];
      ld_size_d = i_ctrlMEM.size;
      ld_zext_d = i_ctrlMEM.sign;
    end
    rej_ld_d  = (rej_mis || rej_af) && is_load;
    mis_d     = rej_mis;
    af_d      = rej_af;
    rd_hold_d = o_readData;
    if (en_IF) begin
      instr_live_d  = 1'b1;
      instr_fault_d = !if_ok;
    end
  end

  // Registered control state with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 2'd0;
      ld_lane_q     <= 2'd0;
      ld_size_q     <= SIZE_W;
      ld_zext_q     <= 1'b0;
      rej_ld_q      <= 1'b0;
      mis_q         <= 1'b0;
      af_q          <= 1'b0;
      rd_hold_q     <= 32'h0;
      instr_live_q  <= 1'b0;
      instr_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_lane_q     <= ld_lane_d;
      ld_size_q     <= ld_size_d;
      ld_zext_q     <= ld_zext_d;
      rej_ld_q      <= rej_ld_d;
      mis_q         <= mis_d;
      af_q          <= af_d;
      rd_hold_q     <= rd_hold_d;
      instr_live_q  <= instr_live_d;
      instr_fault_q <= instr_fault_d;
    end
  end

  assign o_memBusy     = (state_q == ST_WAIT) || ((state_q == ST_RESP) && MULTI);
  assign o_readValid   = (state_q == ST_RESP) || rej_ld_q;
  assign o_readData    = (state_q == ST_RESP) ? extend_load(ld_pipe[DATA_LATENCY-1], ld_lane_q,
                                                            ld_size_q, ld_zext_q)
                       : rej_ld_q ? 32'h0 : rd_hold_q;
  assign o_misaligned  = mis_q;
  assign o_accessFault = af_q;
  assign o_instrFault  = instr_fault_q;
  assign o_instr       = !instr_live_q ? 32'h0 : (instr_fault_q ? NOP : instr_word);

endmodule

// File: tb/tb_mem_unified_ram.sv
// Scoreboard bench for mem_unified_ram. Three instances:
// dut0 uses latency 1, dut1 latency 3, and dut2 base 0x8000_0000 / 256 words / latency 4.
// Expected load data is queued when a load is driven and a negedge monitor pops it on o_readValid.
module tb_mem_unified_ram;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        en_if [3];
  logic [31:0] instr_addr [3];
  logic [31:0] instr [3];
  logic        instr_fault [3];
  logic        en_mem [3];
  logic [31:0] mem_addr [3];
  logic [31:0] wdata [3];
  logic [4:0]  ctrl [3];          // {memRead, memWrite, size, sign}
  logic [31:0] rdata [3];
  logic        rvalid [3], busy [3], mis [3], af [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_unified_ram #(
      .DEPTH_WORDS  (g == 2 ? 256 : 8192),
      .BASE_ADDR    (g == 2 ? 32'h8000_0000 : 32'h0),
      .DATA_LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n[g]),
      .en_IF         (en_if[g]),
      .i_instrAddr   (instr_addr[g]),
      .o_instr       (instr[g]),
      .o_instrFault  (instr_fault[g]),
      .en_MEM        (en_mem[g]),
      .i_memAddr     (mem_addr[g]),
      .i_writeData   (wdata[g]),
      .i_ctrlMEM     (ctrl[g]),
      .o_readData    (rdata[g]),
      .o_readValid   (rvalid[g]),
      .o_memBusy     (busy[g]),
      .o_misaligned  (mis[g]),
      .o_accessFault (af[g])
    );
  end

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every returned load is compared against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (rvalid[g] === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid dut%0d: got data %h expected no response", g, rdata[g]);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("resp_dut%0d", g), 32'(g), 32'(e.dut));
          check($sformatf("rdata_dut%0d", g), rdata[g], e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int g, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size);
    en_mem[g]   = 1'b1;
    ctrl[g]     = {1'b0, 1'b1, size, 1'b0};
    mem_addr[g] = addr;
    wdata[g]    = data;
    tick();
    en_mem[g]   = 1'b0;
    ctrl[g]     = '0;
  endtask

  task automatic do_load(input int g, input logic [31:0] addr, input logic [1:0] size,
                         input logic zext, input logic [31:0] exp, input bit push);
    if (push) sb_q.push_back({2'(g), exp});
    en_mem[g]   = 1'b1;
    ctrl[g]     = {1'b1, 1'b0, size, zext};
    mem_addr[g] = addr;
    tick();
    en_mem[g]   = 1'b0;
    ctrl[g]     = '0;
  endtask

  task automatic do_fetch(input int g, input logic [31:0] addr);
    en_if[g]      = 1'b1;
    instr_addr[g] = addr;
    tick();
    en_if[g]      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0; en_if[g] = 1'b0; instr_addr[g] = '0; en_mem[g] = 1'b0;
      mem_addr[g] = '0; wdata[g] = '0; ctrl[g] = '0;
    end
    repeat (2) tick();
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;

    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_instr%0d", g),  instr[g], 32'h0);
      check($sformatf("rst_ifault%0d", g), instr_fault[g], 32'h0);
      check($sformatf("rst_rdata%0d", g),  rdata[g], 32'h0);
      check($sformatf("rst_valid%0d", g),  rvalid[g], 32'h0);
      check($sformatf("rst_busy%0d", g),   busy[g], 32'h0);
      check($sformatf("rst_mis%0d", g),    mis[g], 32'h0);
      check($sformatf("rst_af%0d", g),     af[g], 32'h0);
    end

    // dut0: store word, then back-to-back sub-word loads at latency 1.
    do_store(0, 32'h100, 32'hDEAD_BEEF, SZ_W);
    check("sw_mis", mis[0], 32'h0);
    check("sw_busy", busy[0], 32'h0);
    do_load(0, 32'h103, SZ_B, 1'b0, 32'hFFFF_FFDE, 1'b1);
    do_load(0, 32'h101, SZ_B, 1'b1, 32'h0000_00BE, 1'b1);
    check("l1_busy", busy[0], 32'h0);
    do_load(0, 32'h102, SZ_H, 1'b0, 32'hFFFF_DEAD, 1'b1);
    do_load(0, 32'h100, SZ_H, 1'b1, 32'h0000_BEEF, 1'b1);
    do_load(0, 32'h100, SZ_W, 1'b0, 32'hDEAD_BEEF, 1'b1);
    drain();
    check("rdata_hold", rdata[0], 32'hDEAD_BEEF);

    // dut0: partial stores and a rejected misaligned half store.
    do_store(0, 32'h200, 32'h5566_7788, SZ_W);
    do_store(0, 32'h201, 32'h0000_AAAA, SZ_H);
    check("sh201_mis", mis[0], 32'h1);
    check("sh201_af", af[0], 32'h0);
    do_load(0, 32'h200, SZ_W, 1'b0, 32'h5566_7788, 1'b1);
    do_store(0, 32'h202, 32'hFFFF_FF99, SZ_B);
    do_load(0, 32'h200, SZ_W, 1'b0, 32'h5599_7788, 1'b1);
    do_store(0, 32'h202, 32'hFFFF_ABCD, SZ_H);
    do_load(0, 32'h200, SZ_W, 1'b0, 32'hABCD_7788, 1'b1);
    do_store(0, 32'h201, 32'h0000_0012, SZ_B);
    do_load(0, 32'h200, SZ_W, 1'b0, 32'hABCD_1288, 1'b1);
    drain();

    // dut0: rejected loads return zero data with a flag pulse.
    do_load(0, 32'h202, SZ_W, 1'b0, 32'h0, 1'b1);
    check("lw202_mis", mis[0], 32'h1);
    check("lw202_valid", rvalid[0], 32'h1);
    do_load(0, 32'h100, 2'b11, 1'b0, 32'h0, 1'b1);
    check("size11_mis", mis[0], 32'h1);
    do_load(0, 32'h8000, SZ_W, 1'b0, 32'h0, 1'b1);
    check("oor_af", af[0], 32'h1);
    check("oor_mis", mis[0], 32'h0);
    do_load(0, 32'h8001, SZ_W, 1'b0, 32'h0, 1'b1);
    check("mis_wins_mis", mis[0], 32'h1);
    check("mis_wins_af", af[0], 32'h0);
    do_store(0, 32'h7FFC, 32'hA5A5_5A5A, SZ_W);
    check("top_word_af", af[0], 32'h0);
    do_load(0, 32'h7FFC, SZ_W, 1'b0, 32'hA5A5_5A5A, 1'b1);
    drain();

    // dut0: load right after store, and read+write together acts as a read.
    do_store(0, 32'h300, 32'hCAFE_F00D, SZ_W);
    do_load(0, 32'h300, SZ_W, 1'b0, 32'hCAFE_F00D, 1'b1);
    sb_q.push_back({2'd0, 32'hCAFE_F00D});
    en_mem[0] = 1'b1; ctrl[0] = {1'b1, 1'b1, SZ_W, 1'b0}; mem_addr[0] = 32'h300; wdata[0] = 32'h0;
    tick();
    en_mem[0] = 1'b0; ctrl[0] = '0;
    do_load(0, 32'h300, SZ_W, 1'b0, 32'hCAFE_F00D, 1'b1);
    drain();

    // dut0: store/fetch collision is read-first; fetch holds and faults.
    do_store(0, 32'h40, 32'h0000_0013, SZ_W);
    en_if[0] = 1'b1; instr_addr[0] = 32'h40;
    do_store(0, 32'h40, 32'h1122_3344, SZ_W);
    check("coll_old", instr[0], 32'h0000_0013);
    check("coll_fault", instr_fault[0], 32'h0);
    tick();
    check("coll_new", instr[0], 32'h1122_3344);
    en_if[0] = 1'b0; instr_addr[0] = 32'h100;
    tick();
    check("fetch_hold", instr[0], 32'h1122_3344);
    do_fetch(0, 32'h42);
    check("fetch_mis_nop", instr[0], 32'h0000_0013);
    check("fetch_mis_fault", instr_fault[0], 32'h1);
    tick();
    check("fetch_fault_hold", instr_fault[0], 32'h1);
    do_fetch(0, 32'h100);
    check("fetch_ok", instr[0], 32'hDEAD_BEEF);
    check("fetch_ok_fault", instr_fault[0], 32'h0);

    // dut1: latency 3 busy window; a load during busy is ignored.
    do_store(1, 32'h100, 32'h0BAD_F00D, SZ_W);
    sb_q.push_back({2'd1, 32'h0BAD_F00D});
    en_mem[1] = 1'b1; ctrl[1] = {1'b1, 1'b0, SZ_W, 1'b0}; mem_addr[1] = 32'h100;
    tick();
    check("l3_busy_t1", busy[1], 32'h1);
    check("l3_valid_t1", rvalid[1], 32'h0);
    mem_addr[1] = 32'h104;
    tick();
    en_mem[1] = 1'b0; ctrl[1] = '0;
    check("l3_busy_t2", busy[1], 32'h1);
    check("l3_valid_t2", rvalid[1], 32'h0);
    tick();
    check("l3_valid_t3", rvalid[1], 32'h1);
    check("l3_busy_t3", busy[1], 32'h1);
    tick();
    check("l3_busy_t4", busy[1], 32'h0);
    check("l3_hold_t4", rdata[1], 32'h0BAD_F00D);
    repeat (6) tick();
    drain();
    do_load(1, 32'h101, SZ_B, 1'b0, 32'hFFFF_FFF0, 1'b1);
    drain();
    do_load(1, 32'h102, SZ_H, 1'b1, 32'h0000_0BAD, 1'b1);
    drain();
    do_load(1, 32'h102, SZ_W, 1'b0, 32'h0, 1'b1);
    check("l3_rej_valid", rvalid[1], 32'h1);
    check("l3_rej_busy", busy[1], 32'h0);
    drain();

    // dut2: base decode, range faults, fetch below base.
    do_load(2, 32'h8000_0400, SZ_W, 1'b0, 32'h0, 1'b1);
    check("b_af", af[2], 32'h1);
    check("b_mis", mis[2], 32'h0);
    drain();
    do_fetch(2, 32'h7FFF_FFFC);
    check("b_fetch_nop", instr[2], 32'h0000_0013);
    check("b_fetch_fault", instr_fault[2], 32'h1);
    do_store(2, 32'h8000_0000, 32'h1234_5678, SZ_W);
    check("b_sw_af", af[2], 32'h0);
    do_fetch(2, 32'h8000_0000);
    check("b_fetch", instr[2], 32'h1234_5678);
    check("b_fetch_fault0", instr_fault[2], 32'h0);
    do_load(2, 32'h8000_0000, SZ_W, 1'b0, 32'h1234_5678, 1'b1);
    drain();

    // dut2: reset two cycles after acceptance drops the load.
    do_load(2, 32'h8000_0000, SZ_W, 1'b0, 32'h0, 1'b0);
    check("rst_mid_busy", busy[2], 32'h1);
    tick();
    rst_n[2] = 1'b0;
    tick();
    check("rst_mid_busy0", busy[2], 32'h0);
    check("rst_mid_valid0", rvalid[2], 32'h0);
    check("rst_mid_instr", instr[2], 32'h0);
    rst_n[2] = 1'b1;
    repeat (6) tick();
    check("rst_mid_idle", busy[2], 32'h0);
    do_load(2, 32'h8000_0000, SZ_W, 1'b0, 32'h1234_5678, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
